// File: rtl/vga_panel_pkg.sv
// Shared types and geometry helpers for the VGA register panel.
package vga_panel_pkg;

  typedef enum logic {LIVE = 1'b0, FROZEN = 1'b1} frz_state_e;
  typedef enum logic {GAP = 1'b0, LED = 1'b1} phase_e;

  localparam logic [23:0] DEF_COLOUR_BG  = 24'h222222;
  localparam logic [23:0] DEF_COLOUR_ON  = 24'hFF0000;
  localparam logic [23:0] DEF_COLOUR_OFF = 24'h444444;

  localparam int LEDS_PER_ROW = 8;

  function automatic int panel_w(input int wg, input int w);
    return wg + (w + wg) * LEDS_PER_ROW;
  endfunction

  function automatic int panel_h(input int n, input int h, input int vg);
    return n * h + (n - 1) * vg;
  endfunction

  function automatic int row_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PANEL_W = panel_w(10, 26);
  localparam int PANEL_H = panel_h(4, 16, 6);

  // Stage-1 segment decode carried to the colour stage.
  typedef struct packed {
    logic [2:0] led;
    phase_e     phase;
  } seg_t;

endpackage

// File: rtl/vga_panel_scan.sv
// Row tracker and column sequencer: turns the raw VGA position into
// (row, led, phase, active) for the pixel currently presented.
module vga_panel_scan
  import vga_panel_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int START_H  = 10,
  parameter int START_V  = 10,
  parameter int W        = 26,
  parameter int H        = 16,
  parameter int WG       = 10,
  parameter int VG       = 6,
  parameter int RW       = row_w(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [10:0]   vga_h_i,
  input  logic [10:0]   vga_v_i,
  output logic [RW-1:0] row_idx_o,
  output logic [2:0]    led_idx_o,
  output phase_e        phase_o,
  output logic          active_o
);

  logic [RW-1:0] row_q, row_c;
  logic [10:0]   lcnt_q, lcnt_c;
  logic          rows_q, rows_c, rgap_q, rgap_c;

  logic          act_q, act_c, act_d;
  logic [3:0]    led_q, led_c, led_d;
  phase_e        ph_q, ph_c, ph_d;
  logic [10:0]   seg_q, seg_c, seg_d;

  // Row state for the current line: advances once, on the line's h==0 pixel.
  always_comb begin
    row_c  = row_q;
    lcnt_c = lcnt_q;
    rows_c = rows_q;
    rgap_c = rgap_q;
    if (vga_h_i == 11'd0) begin
      if (vga_v_i == 11'(START_V)) begin
        row_c  = '0;
        lcnt_c = '0;
        rows_c = 1'b1;
        rgap_c = 1'b0;
      end else if (rows_q) begin
        if (!rgap_q) begin
          if (lcnt_q == 11'(H - 1)) begin
            lcnt_c = '0;
            if (row_q == RW'(NUM_REGS - 1)) rows_c = 1'b0;
            else                           rgap_c = 1'b1;
          end else begin
            lcnt_c = lcnt_q + 11'd1;
          end
        end else if (lcnt_q == 11'(VG - 1)) begin
          lcnt_c = '0;
          rgap_c = 1'b0;
          row_c  = row_q + 1'b1;
        end else begin
          lcnt_c = lcnt_q + 11'd1;
        end
      end
    end
  end

  // Column state for the current pixel; led index 8 is the closing gap.
  always_comb begin
    act_c = act_q;
    led_c = led_q;
    ph_c  = ph_q;
    seg_c = seg_q;
    if (vga_h_i == 11'(START_H)) begin
      act_c = 1'b1;
      led_c = '0;
      ph_c  = GAP;
      seg_c = '0;
    end
    act_d = act_c;
    led_d = led_c;
    ph_d  = ph_c;
    seg_d = seg_c + 11'd1;
    if (act_c) begin
      if (ph_c == GAP && seg_c == 11'(WG - 1)) begin
        seg_d = '0;
        if (led_c == 4'(LEDS_PER_ROW)) act_d = 1'b0;
        else                           ph_d  = LED;
      end else if (ph_c == LED && seg_c == 11'(W - 1)) begin
        seg_d = '0;
        ph_d  = GAP;
        led_d = led_c + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q  <= '0;
      lcnt_q <= '0;
      rows_q <= 1'b0;
      rgap_q <= 1'b0;
      act_q  <= 1'b0;
      led_q  <= '0;
      ph_q   <= GAP;
      seg_q  <= '0;
    end else begin
      row_q  <= row_c;
      lcnt_q <= lcnt_c;
      rows_q <= rows_c;
      rgap_q <= rgap_c;
      act_q  <= act_d;
      led_q  <= led_d;
      ph_q   <= ph_d;
      seg_q  <= seg_d;
    end
  end

  assign row_idx_o = row_c;
  assign led_idx_o = led_c[2:0];
  assign phase_o   = (ph_c == LED && !rgap_c) ? LED : GAP;
  assign active_o  = rows_c && act_c;

endmodule

// File: rtl/vga_register_panel.sv
// Register LED panel: per-frame shadow snapshot with freeze handshake,
// scan decode, and a two-stage decode/colour pipeline.
module vga_register_panel
  import vga_panel_pkg::*;
#(
  parameter int          NUM_REGS   = 4,
  parameter int          START_H    = 10,
  parameter int          START_V    = 10,
  parameter int          W          = 26,
  parameter int          H          = 16,
  parameter int          WG         = 10,
  parameter int          VG         = 6,
  parameter logic [23:0] COLOUR_BG  = DEF_COLOUR_BG,
  parameter logic [23:0] COLOUR_ON  = DEF_COLOUR_ON,
  parameter logic [23:0] COLOUR_OFF = DEF_COLOUR_OFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [8*NUM_REGS-1:0] regs_in,
  input  logic [10:0]           vga_h,
  input  logic [10:0]           vga_v,
  input  logic                  freeze_req,
  output logic                  freeze_ack,
  output logic [23:0]           pixel_out,
  output logic                  display_on
);

  localparam int RW     = row_w(NUM_REGS);
  localparam int STAGES = 2;

  logic [NUM_REGS-1:0][7:0] shadow_q;
  frz_state_e               state_q;
  logic                     ack_q;
  logic                     fs;

  logic [RW-1:0] scan_row, row_q;
  logic [2:0]    scan_led;
  phase_e        scan_phase;
  logic          scan_active;
  seg_t          seg_q;
  logic [STAGES:1] vld_pipe_q;
  logic [23:0]   pix_q;

  assign fs = (vga_h == 11'd0) && (vga_v == 11'd0);

  // Freeze FSM only looks at freeze_req on the frame-start cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= LIVE;
      ack_q    <= 1'b0;
      shadow_q <= '0;
    end else if (fs) begin
      case (state_q)
        LIVE: begin
          shadow_q <= regs_in;
          if (freeze_req) begin
            state_q <= FROZEN;
            ack_q   <= 1'b1;
          end
        end
        FROZEN: begin
          if (!freeze_req) begin
            state_q  <= LIVE;
            ack_q    <= 1'b0;
            shadow_q <= regs_in;
          end
        end
        default: state_q <= LIVE;
      endcase
    end
  end

  vga_panel_scan #(
    .NUM_REGS (NUM_REGS),
    .START_H  (START_H),
    .START_V  (START_V),
    .W        (W),
    .H        (H),
    .WG       (WG),
    .VG       (VG),
    .RW       (RW)
  ) u_scan (
    .clk       (clk),
    .reset_n   (reset_n),
    .vga_h_i   (vga_h),
    .vga_v_i   (vga_v),
    .row_idx_o (scan_row),
    .led_idx_o (scan_led),
    .phase_o   (scan_phase),
    .active_o  (scan_active)
  );

  // Stage 1 holds the decode, stage 2 the colour; MSB is the leftmost LED.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      row_q      <= '0;
      seg_q      <= '{led: 3'd0, phase: GAP};
      pix_q      <= COLOUR_BG;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], scan_active};
      row_q      <= scan_row;
      seg_q      <= '{led: scan_led, phase: scan_phase};
      if (vld_pipe_q[1] && seg_q.phase == LED)
        pix_q <= shadow_q[row_q][3'd7 - seg_q.led] ? COLOUR_ON : COLOUR_OFF;
      else
        pix_q <= COLOUR_BG;
    end
  end

  assign freeze_ack = ack_q;
  assign pixel_out  = pix_q;
  assign display_on = vld_pipe_q[STAGES];

endmodule

// File: tb/tb_vga_register_panel.sv
// Randomized frame-level bench for vga_register_panel against a geometric model.
module tb_vga_register_panel;

  localparam int NR = 4, SH = 10, SV = 10, W = 26, H = 16, WG = 10, VG = 6;
  localparam int PW = WG + (W + WG) * 8;
  localparam int PH = NR * H + (NR - 1) * VG;
  localparam int HT = 312;
  localparam int VEND = SV + PH;
  localparam logic [23:0] BG = 24'h222222, ON = 24'hFF0000, OFF = 24'h444444;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   regs_in;
  logic [10:0]   vga_h, vga_v;
  logic          freeze_req;
  logic          freeze_ack;
  logic [23:0]   pixel_out;
  logic          display_on;

  always #5 clk = ~clk;

  vga_register_panel dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .regs_in    (regs_in),
    .vga_h      (vga_h),
    .vga_v      (vga_v),
    .freeze_req (freeze_req),
    .freeze_ack (freeze_ack),
    .pixel_out  (pixel_out),
    .display_on (display_on)
  );

  int total = 0, bad = 0;

  logic [7:0]  m_sh [NR];
  bit          m_frz, v_arm, h_arm, skip, jumped, lit_en;
  logic [23:0] e1_pix, e2_pix;
  bit          e1_on, e2_on, e1_ck, e2_ck;
  int          e1_h, e1_v, e2_h, e2_v;

  localparam int NL = 12;
  int          lit_v [NL] = '{10, 10, 10, 10, 10, 10, 26, 31, 32, 32, 25, 25};
  int          lit_h [NL] = '{20, 19, 56, 9, 308, 307, 30, 30, 20, 272, 45, 46};
  logic [23:0] lit_p [NL] = '{ON, BG, OFF, BG, BG, BG, BG, BG, OFF, ON, ON, BG};
  bit          lit_o [NL] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 25) $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected output straight from panel geometry and the snapshot.
  function automatic void calc(input int h, input int v, output logic [23:0] p, output bit on);
    int cp, ln, k, o;
    on = v_arm && h_arm && v >= SV && v < SV + PH && h >= SH && h < SH + PW;
    p  = BG;
    if (on) begin
      cp = h - SH;
      ln = v - SV;
      if ((ln % (H + VG)) < H && cp >= WG) begin
        k = (cp - WG) / (W + WG);
        o = (cp - WG) % (W + WG);
        if (o < W) p = m_sh[ln / (H + VG)][7 - k] ? ON : OFF;
      end
    end
  endfunction

  always @(posedge clk) begin
    logic [23:0] p;
    bit o;
    if (!reset_n) begin
      m_frz = 0; v_arm = 0; h_arm = 0; skip = 0;
      for (int i = 0; i < NR; i++) m_sh[i] = 8'h00;
      e1_pix = BG; e1_on = 0; e1_ck = 1; e1_h = -1; e1_v = -1;
      e2_pix = BG; e2_on = 0; e2_ck = 1; e2_h = -1; e2_v = -1;
    end else begin
      if (vga_h == 0 && vga_v == 0) begin
        if (!m_frz || !freeze_req)
          for (int i = 0; i < NR; i++) m_sh[i] = regs_in[8*i +: 8];
        m_frz = freeze_req;
      end
      if (vga_h == 0 && vga_v == SV) v_arm = 1;
      if (vga_h == SH) begin h_arm = 1; skip = 0; end
      if (jumped) skip = 1;
      calc(int'(vga_h), int'(vga_v), p, o);
      e2_pix = e1_pix; e2_on = e1_on; e2_ck = e1_ck; e2_h = e1_h; e2_v = e1_v;
      e1_pix = p; e1_on = o; e1_ck = !skip; e1_h = int'(vga_h); e1_v = int'(vga_v);
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset pixel", pixel_out, BG);
      chk("reset on", display_on, 0);
      chk("reset ack", freeze_ack, 0);
    end else begin
      chk("ack", freeze_ack, m_frz);
      if (e2_ck) begin
        chk($sformatf("pix h=%0d v=%0d", e2_h, e2_v), pixel_out, e2_pix);
        chk($sformatf("on h=%0d v=%0d", e2_h, e2_v), display_on, e2_on);
      end
      if (lit_en)
        for (int i = 0; i < NL; i++)
          if (e2_v == lit_v[i] && e2_h == lit_h[i]) begin
            chk($sformatf("literal pix h=%0d v=%0d", e2_h, e2_v), pixel_out, lit_p[i]);
            chk($sformatf("literal on h=%0d v=%0d", e2_h, e2_v), display_on, lit_o[i]);
          end
    end
  end

  task automatic run_line(input int v, input bit full, input int jump_at, input int rst_at);
    int h = 0;
    int last = full ? HT - 1 : 2;
    while (h <= last) begin
      if (h == jump_at) begin h = 200; jumped = 1; end
      if (h == rst_at) begin
        reset_n = 0;
        #1;
        chk("reset now pixel", pixel_out, BG);
        chk("reset now on", display_on, 0);
        chk("reset now ack", freeze_ack, 0);
      end
      if (rst_at >= 0 && h == rst_at + 3) reset_n = 1;
      vga_h = 11'(h);
      vga_v = 11'(v);
      @(posedge clk); #1;
      jumped = 0;
      h++;
    end
  endtask

  task automatic run_frame(input bit do_fs, input int exp_ack, input int chg_v,
                           input logic [31:0] chg_val, input int req_v, input bit req_val,
                           input int jump_v, input int rst_v);
    bit full;
    if (do_fs) begin
      vga_h = 0; vga_v = 0;
      @(posedge clk); #1;
      if (exp_ack >= 0) chk("ack after frame start", freeze_ack, exp_ack);
    end
    for (int v = 1; v <= VEND; v++) begin
      if (v == chg_v) regs_in = chg_val;
      if (v == req_v) freeze_req = req_val;
      full = (v == SV) || (v == SV + H - 1) || (v == SV + H) || (v == SV + H + VG - 1) ||
             (v == SV + H + VG) || (v == SV + PH - 1) || (v == SV + PH) ||
             (v == jump_v) || (v == jump_v + 1) || (v == rst_v) || ($urandom_range(0, 15) == 0);
      run_line(v, full, (v == jump_v) ? 50 : -1, (v == rst_v) ? 100 : -1);
    end
  endtask

  initial begin
    reset_n = 0; regs_in = '0; vga_h = 0; vga_v = 11'd1023;
    freeze_req = 0; jumped = 0; lit_en = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    regs_in = 32'h0000_0180;
    lit_en = 1;
    run_frame(1, 0, -1, '0, -1, 0, -1, -1);
    lit_en = 0;

    regs_in = 32'h0;
    run_frame(1, 0, 40, 32'hFFFF_FFFF, -1, 0, -1, -1);
    run_frame(1, 0, -1, '0, -1, 0, -1, -1);

    regs_in = $urandom;
    run_frame(1, 0, -1, '0, 50, 1, -1, -1);
    chk("ack before next frame start", freeze_ack, 0);
    run_frame(1, 1, 20, $urandom, -1, 0, -1, -1);
    run_frame(1, 1, 40, $urandom, 30, 0, -1, -1);
    run_frame(1, 0, -1, '0, -1, 0, -1, -1);

    regs_in = $urandom;
    run_frame(1, 0, -1, '0, -1, 0, SV + 5, -1);
    run_frame(1, 0, -1, '0, -1, 0, -1, SV + 2 * (H + VG) + 3);
    run_frame(0, -1, -1, '0, -1, 0, -1, -1);

    for (int f = 0; f < 2; f++) begin
      regs_in = $urandom;
      run_frame(1, -1, $urandom_range(1, VEND), $urandom, $urandom_range(1, VEND),
                1'($urandom_range(0, 1)), -1, -1);
    end

    run_line(1, 0, -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
